// File: rtl/dmem_request_master.sv
// dmem_request_master
// Accepts one load/store request at a time from the pipeline. It issues the
// request on the data-memory port and returns a single response.
// Loads wait LATENCY cycles for dmem_readdata. Stores respond right after the
// access cycle.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word requests and reserved sizes are answered with rsp_error=1 and never
// reach memory.
// LATENCY must be in 1..4.

module dmem_request_master #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,

    output logic [31:0] dmem_address,
    output logic [31:0] dmem_writedata,
    output logic        dmem_memread,
    output logic        dmem_memwrite,
    output logic [1:0]  dmem_maskmode,
    output logic        dmem_sext,
    input  logic [31:0] dmem_readdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The wait counter is loaded with LATENCY and counts down to 1.
    localparam logic [2:0] CNT_INIT = 3'(LATENCY);

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        error_reg, error_next;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic        write_reg;

    logic        hs;
    logic        req_bad;

    // req_ready is gated by reset_n so that it only rises once reset is released.
    assign req_ready = (state_reg == IDLE) && reset_n;
    assign hs        = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misaligned half, misaligned word and the reserved size are rejected up front.
    assign req_bad = (req_size == 2'd3) ||
                     ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    // With trapping disabled every request goes to memory as-is.
    // error_reg therefore never leaves 0, and rsp_error stays tied low.
    assign req_bad = 1'b0;
`endif

    // Request capture: everything the memory port needs is frozen at handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg   <= '0;
            wdata_reg  <= '0;
            size_reg   <= '0;
            signed_reg <= 1'b0;
            write_reg  <= 1'b0;
        end else if (hs) begin
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            write_reg  <= req_write;
        end
    end

    // State, wait counter and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            error_reg <= error_next;
        end
    end

    // Next-state logic. The response data and error are settled before RESP is entered.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        error_next = error_reg;
        case (state_reg)
            IDLE: begin
                if (hs) begin
                    rdata_next = '0;
                    error_next = req_bad;
                    state_next = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (write_reg) begin
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                    cnt_next   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd1) begin
                    state_next = RESP;
                    rdata_next = dmem_readdata;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes last only for the single access cycle.
    // The address, data and mode outputs come straight from the capture registers.
    assign dmem_memread   = (state_reg == ACCESS) && !write_reg;
    assign dmem_memwrite  = (state_reg == ACCESS) &&  write_reg;
    assign dmem_address   = addr_reg;
    assign dmem_writedata = wdata_reg;
    assign dmem_maskmode  = size_reg;
    assign dmem_sext      = signed_reg;

    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_error = error_reg;

endmodule

// File: doc/dmem_request_master.md
DMEM_REQUEST_MASTER -- requirements
Module: dmem_request_master

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from the access cycle until dmem_readdata is valid; legal range 1..4.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  pipeline request present.
REQ-005 SHALL have port req_ready  out  1  unit can accept a request.
REQ-006 SHALL have port req_write  in  1  1 store, 0 load.
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_wdata  in  32  store data.
REQ-009 SHALL have port req_size  in  2  0 byte, 1 half, 2 word, 3 reserved.
REQ-010 SHALL have port req_signed  in  1  sign-extend load result.
REQ-011 SHALL have port rsp_valid  out  1  response present.
REQ-012 SHALL have port rsp_ready  in  1  pipeline accepts response.
REQ-013 SHALL have port rsp_rdata  out  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_error  out  1  request rejected as misaligned/illegal.
REQ-015 SHALL have ports dmem_address out 32, dmem_writedata out 32, dmem_memread out 1, dmem_memwrite out 1, dmem_maskmode out 2, dmem_sext out 1, dmem_readdata in 32: the initiator side of the data-memory port.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; handshake is req_valid&&req_ready on a rising edge.
REQ-018 SHALL, on handshake, register addr/wdata/size/signed/write and go to ACCESS next cycle.
REQ-019 SHALL, in ACCESS, assert exactly one of dmem_memread (load) or dmem_memwrite (store) for exactly one cycle.
REQ-020 SHALL hold dmem_address, dmem_writedata, dmem_maskmode=req_size, dmem_sext=req_signed stable from ACCESS through end of WAIT.
REQ-021 SHALL, after a store ACCESS, go directly to RESP with rsp_rdata=0.
REQ-022 SHALL, after a load ACCESS, remain in WAIT exactly LATENCY cycles via a down-counter, capture dmem_readdata into rsp_rdata on the edge ending the last WAIT cycle, then go to RESP.
REQ-023 SHALL, in RESP, hold rsp_valid=1 and rsp_rdata/rsp_error stable until rsp_ready=1; on that edge return to IDLE.
REQ-024 SHALL have load-to-response latency of 2+LATENCY cycles after handshake when rsp_ready is held 1; store 2 cycles.
REQ-025 SHALL not accept a new request in the cycle RESP completes; next acceptance is the following IDLE cycle.
REQ-026 SHALL drive dmem_memread=dmem_memwrite=0 in IDLE, WAIT and RESP.

Reset
REQ-027 SHALL, on reset_n=0, immediately (asynchronously) enter IDLE and clear all outputs to 0 except req_ready, which goes to 1 after reset_n deasserts.
REQ-028 SHALL abandon any in-flight request on reset with no response and no memory strobe thereafter.

Configuration
REQ-029 SHALL, with macro DMEM_MISALIGN_TRAP_EN defined, treat half with addr[0]=1, word with addr[1:0]!=0, or size=3 as an error: skip ACCESS, go IDLE->RESP with rsp_error=1, rsp_rdata=0, no strobe.
REQ-030 SHALL, without DMEM_MISALIGN_TRAP_EN, issue every request to memory unchanged and tie rsp_error=0.

Verification
REQ-031 SHALL cover: LATENCY=1, load addr 0x100 size 2, memory returns 0xDEADBEEF -> single memread pulse, rsp_valid 3 cycles after handshake, rsp_rdata=0xDEADBEEF.
REQ-032 SHALL cover: store addr 0x104 wdata 0x12345678 size 2 -> one memwrite pulse, address/data held, rsp_valid 2 cycles after handshake, rsp_rdata=0.
REQ-033 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, no dmem strobe.
REQ-034 SHALL cover: with DMEM_MISALIGN_TRAP_EN, word load at 0x102 -> no strobe, rsp_error=1 one cycle after handshake; without the macro -> memread issued, rsp_error=0.
REQ-035 SHALL cover: LATENCY=4, reset_n pulsed low during WAIT -> outputs 0 asynchronously, no response, next load completes normally in 6 cycles.
